// File: rtl/serv_lsu_ctrl_pkg.sv
// Shared types and helpers for the SERV load/store sequencer.
// States, access sizes, byte-lane, misalign and load-extension helpers.
package serv_lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRAP  = 3'd1,
    S_BUS   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int XLEN = 32;

  function automatic size_e size_f(
    input logic word,
    input logic half
  );
    size_f = word ? SZ_WORD : (half ? SZ_HALF : SZ_BYTE);
  endfunction

  // Lane 0 is only ever driven by an access starting at byte 0;
  // halfwords always reach their upper lane within the word.
  function automatic logic [3:0] sel_f(
    input size_e      sz,
    input logic [1:0] lsb
  );
    logic w;
    logic h;
    w = (sz == SZ_WORD);
    h = (sz == SZ_HALF);
    sel_f[3] = (lsb == 2'd3) | w | (h & lsb[1]);
    sel_f[2] = (lsb == 2'd2) | w;
    sel_f[1] = (lsb == 2'd1) | w | (h & ~lsb[1]);
    sel_f[0] = (lsb == 2'd0);
  endfunction

  function automatic logic mis_f(
    input size_e      sz,
    input logic [1:0] lsb
  );
    logic w;
    logic h;
    w = (sz == SZ_WORD);
    h = (sz == SZ_HALF);
    mis_f = (lsb[0] & (w | h)) | (lsb[1] & w);
  endfunction

  function automatic logic [XLEN-1:0] ext_f(
    input logic [XLEN-1:0] rdt,
    input logic [1:0]      lsb,
    input size_e           sz,
    input logic            sgn
  );
    logic [XLEN-1:0] sh;
    sh = rdt >> {lsb, 3'b000};
    unique case (sz)
      SZ_BYTE: ext_f = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: ext_f = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ext_f = sh;
    endcase
  endfunction

endpackage

// File: rtl/serv_lsu_ctrl_shift.sv
// Load result path: captures extended read data, streams it W bits/cycle.
// Ports: clk/rst, capture + shift strobes, read data/lsb/size/sign, o_rd and last flags.
module serv_lsu_ctrl_shift
  import serv_lsu_ctrl_pkg::*;
#(
  parameter int W = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cap,
  input  logic            i_shift,
  input  logic [XLEN-1:0] i_rdt,
  input  logic [1:0]      i_lsb,
  input  size_e           i_size,
  input  logic            i_signed,
  output logic [W-1:0]    o_rd,
  output logic            o_last,
  output logic            o_penult
);

  localparam int CHUNKS = XLEN / W;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [XLEN-1:0] cap_q;
  logic [XLEN-1:0] cap_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [XLEN-1:0] rd_sh;

  assign cap_d = ext_f(i_rdt, i_lsb, i_size, i_signed);

  assign o_last = (cnt_q == CW'(CHUNKS - 1));
  assign o_penult = (CHUNKS > 1) &&
                    (cnt_q == CW'(CHUNKS - 2));

  // Counter wraps back to 0 as the last chunk leaves.
  assign cnt_d = o_last ? '0 : cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else if (i_cap) begin
      cap_q <= cap_d;
      cnt_q <= '0;
    end else if (i_shift) begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_sh = cap_q >> (32'(cnt_q) * W);
  assign o_rd = rd_sh[W-1:0];

endmodule

// File: rtl/serv_lsu_ctrl.sv
// Load/store sequencer for SERV: alignment check, one Wishbone cycle, load streaming.
// Ports: core request (i_req..i_wdat), status (o_busy/o_misalign/o_done), o_rd stream, Wishbone.
module serv_lsu_ctrl
  import serv_lsu_ctrl_pkg::*;
#(
  parameter int WITH_CSR = 1,
  parameter int W        = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic            i_we,
  input  logic            i_signed,
  input  logic            i_word,
  input  logic            i_half,
  input  logic [XLEN-1:0] i_adr,
  input  logic [XLEN-1:0] i_wdat,
  output logic            o_busy,
  output logic            o_misalign,
  output logic            o_done,
  output logic [W-1:0]    o_rd,
  output logic            o_rd_valid,
  output logic [XLEN-1:0] o_wb_adr,
  output logic [XLEN-1:0] o_wb_dat,
  output logic [3:0]      o_wb_sel,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  input  logic [XLEN-1:0] i_wb_rdt,
  input  logic            i_wb_ack
);

  localparam int CHUNKS = XLEN / W;

  state_e          state_q;
  size_e           size_q;
  size_e           size_d;
  logic [1:0]      lsb_q;
  logic            signed_q;
  logic            busy_q;
  logic            mis_q;
  logic            done_q;
  logic            rdv_q;
  logic            cyc_q;
  logic            we_q;
  logic [XLEN-1:0] adr_q;
  logic [XLEN-1:0] dat_q;
  logic [XLEN-1:0] dat_d;
  logic [3:0]      sel_q;
  logic [3:0]      sel_d;
  logic            mis_d;
  logic            cap;
  logic            shift;
  logic            last;
  logic            penult;

  assign size_d = size_f(i_word, i_half);
  assign sel_d = sel_f(size_d, i_adr[1:0]);
  assign dat_d = i_wdat << {i_adr[1:0], 3'b000};
  assign mis_d = (WITH_CSR != 0) &&
                 mis_f(size_d, i_adr[1:0]);

  assign cap = (state_q == S_BUS) & i_wb_ack & ~we_q;
  assign shift = (state_q == S_SHIFT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      size_q   <= SZ_BYTE;
      lsb_q    <= '0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
      done_q   <= 1'b0;
      rdv_q    <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
    end else begin
      mis_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_req) begin
            size_q   <= size_d;
            lsb_q    <= i_adr[1:0];
            signed_q <= i_signed;
            we_q     <= i_we;
            adr_q    <= {i_adr[XLEN-1:2], 2'b00};
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            busy_q   <= 1'b1;
            if (mis_d) begin
              state_q <= S_TRAP;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_BUS;
              cyc_q   <= 1'b1;
            end
          end
        end
        S_TRAP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_BUS: begin
          if (i_wb_ack) begin
            cyc_q <= 1'b0;
            if (we_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              rdv_q   <= 1'b1;
              // Single-chunk stream completes on its first beat.
              done_q  <= (CHUNKS == 1);
            end
          end
        end
        S_SHIFT: begin
          if (last) begin
            state_q <= S_IDLE;
            rdv_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            done_q <= penult;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cyc_q   <= 1'b0;
          rdv_q   <= 1'b0;
        end
      endcase
    end
  end

  serv_lsu_ctrl_shift #(
    .W(W)
  ) u_shift (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_cap    (cap),
    .i_shift  (shift),
    .i_rdt    (i_wb_rdt),
    .i_lsb    (lsb_q),
    .i_size   (size_q),
    .i_signed (signed_q),
    .o_rd     (o_rd),
    .o_last   (last),
    .o_penult (penult)
  );

  assign o_busy     = busy_q;
  assign o_misalign = mis_q;
  assign o_done     = done_q;
  assign o_rd_valid = rdv_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_we    = we_q;
  assign o_wb_cyc   = cyc_q;

endmodule

// File: tb/tb_serv_lsu_ctrl.sv
// Bench for serv_lsu_ctrl: two instances (trapping W=1, non-trapping W=4).
// Reference model computes lanes, data and load streams arithmetically.
module tb_serv_lsu_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic we, sgn, word, half;
  logic [31:0] adr, wdat, rdt;
  logic ack0, ack1;

  logic busy0, mis0, done0, rdv0, wbwe0, cyc0;
  logic [0:0] rd0;
  logic [31:0] wadr0, wdat0;
  logic [3:0] sel0;
  logic busy1, mis1, done1, rdv1, wbwe1, cyc1;
  logic [3:0] rd1;
  logic [31:0] wadr1, wdat1;
  logic [3:0] sel1;

  int dsel = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_lsu_ctrl #(.WITH_CSR(1), .W(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we),
    .i_signed(sgn), .i_word(word), .i_half(half),
    .i_adr(adr), .i_wdat(wdat), .o_busy(busy0),
    .o_misalign(mis0), .o_done(done0), .o_rd(rd0),
    .o_rd_valid(rdv0), .o_wb_adr(wadr0), .o_wb_dat(wdat0),
    .o_wb_sel(sel0), .o_wb_we(wbwe0), .o_wb_cyc(cyc0),
    .i_wb_rdt(rdt), .i_wb_ack(ack0)
  );

  serv_lsu_ctrl #(.WITH_CSR(0), .W(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we),
    .i_signed(sgn), .i_word(word), .i_half(half),
    .i_adr(adr), .i_wdat(wdat), .o_busy(busy1),
    .o_misalign(mis1), .o_done(done1), .o_rd(rd1),
    .o_rd_valid(rdv1), .o_wb_adr(wadr1), .o_wb_dat(wdat1),
    .o_wb_sel(sel1), .o_wb_we(wbwe1), .o_wb_cyc(cyc1),
    .i_wb_rdt(rdt), .i_wb_ack(ack1)
  );

  wire s_busy = (dsel != 0) ? busy1 : busy0;
  wire s_mis  = (dsel != 0) ? mis1  : mis0;
  wire s_done = (dsel != 0) ? done1 : done0;
  wire s_rdv  = (dsel != 0) ? rdv1  : rdv0;
  wire s_cyc  = (dsel != 0) ? cyc1  : cyc0;
  wire s_we   = (dsel != 0) ? wbwe1 : wbwe0;
  wire [3:0] s_sel = (dsel != 0) ? sel1 : sel0;
  wire [31:0] s_adr = (dsel != 0) ? wadr1 : wadr0;
  wire [31:0] s_dat = (dsel != 0) ? wdat1 : wdat0;
  wire [31:0] s_rd = (dsel != 0) ? {28'd0, rd1} : {31'd0, rd0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ack(input int d, input logic v);
    if (d != 0) ack1 = v;
    else ack0 = v;
  endtask

  task automatic txn(input int d, input bit w_e, input bit sg,
                     input int sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd_data,
                     input int dly, input bit poke);
    int lsb, wbits, chunks, n;
    bit mis;
    logic [3:0] esel;
    logic [31:0] sh;
    longint unsigned mask, val, chunk;
    lsb = int'(a[1:0]);
    wbits = (d != 0) ? 4 : 1;
    chunks = 32 / wbits;
    n = 8 << sz;
    // Misaligned means the address is not a multiple of the access size.
    mis = (d == 0) && ((a % (32'd1 << sz)) != 0);
    for (int k = 0; k < 4; k++)
      esel[k] = (lsb == k) || (k > 0 && (sz == 2 ||
                (sz == 1 && k == (lsb & 2) + 1)));
    sh = rd_data >> (8 * lsb);
    mask = (64'd1 << n) - 1;
    val = longint'(sh) & mask;
    if (sg && sh[n-1]) val = val | (~mask & 64'hFFFF_FFFF);

    @(negedge clk);
    dsel = d;
    we = w_e; sgn = sg; word = (sz == 2); half = (sz == 1);
    adr = a; wdat = wd; rdt = rd_data;
    if (d != 0) req1 = 1'b1;
    else req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    if (mis) begin
      chk("trap_pulse", s_mis, 1);
      chk("trap_cyc", s_cyc, 0);
      chk("trap_busy", s_busy, 1);
      @(negedge clk);
      chk("trap_end", s_mis, 0);
      chk("trap_idle", s_busy, 0);
      chk("trap_nocyc", s_cyc, 0);
      return;
    end
    chk("cyc_t1", s_cyc, 1);
    chk("wb_adr", s_adr, a & ~32'd3);
    chk("wb_sel", s_sel, esel);
    chk("wb_we", s_we, w_e);
    chk("busy", s_busy, 1);
    if (w_e) chk("wb_dat", s_dat, wd << (8 * lsb));
    for (int i = 0; i < dly; i++) begin
      if (poke) begin
        if (d != 0) req1 = 1'b1;
        else req0 = 1'b1;
        adr = ~a; word = ~word; we = ~we;
      end
      @(negedge clk);
      chk("cyc_wait", s_cyc, 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    set_ack(d, 1'b1);
    @(negedge clk);
    set_ack(d, 1'b0);
    chk("cyc_drop", s_cyc, 0);
    chk("adr_held", s_adr, a & ~32'd3);
    chk("sel_held", s_sel, esel);
    if (w_e) begin
      chk("st_done", s_done, 1);
      chk("st_rdv", s_rdv, 0);
      chk("st_busy", s_busy, 1);
      @(negedge clk);
      chk("st_done_end", s_done, 0);
      chk("st_idle", s_busy, 0);
    end else begin
      for (int c = 0; c < chunks; c++) begin
        chunk = (val >> (c * wbits)) & ((64'd1 << wbits) - 1);
        chk("ld_rdv", s_rdv, 1);
        chk("ld_chunk", s_rd, 32'(chunk));
        chk("ld_done", s_done, 32'(c == chunks - 1));
        @(negedge clk);
      end
      chk("ld_rdv_end", s_rdv, 0);
      chk("ld_idle", s_busy, 0);
      chk("ld_done_end", s_done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
    we = 0; sgn = 0; word = 0; half = 0;
    adr = '0; wdat = '0; rdt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_cyc", {cyc0, cyc1}, 0);
    chk("rst_flags", {mis0, done0, rdv0, mis1, done1, rdv1}, 0);
    chk("rst_adr", wadr0 | wadr1, 0);
    chk("rst_dat", wdat0 | wdat1, 0);
    chk("rst_sel", {sel0, sel1, wbwe0, wbwe1}, 0);
    chk("rst_rd", {rd0, rd1}, 0);
    rst = 1'b0;
    @(negedge clk);

    txn(0, 0, 0, 2, 32'h1000, 0, 32'h89ABCDEF, 2, 0);
    txn(0, 0, 1, 0, 32'h1003, 0, 32'h80123456, 1, 1);
    txn(1, 0, 0, 1, 32'h1002, 0, 32'hBEEF0000, 0, 0);
    txn(0, 1, 0, 1, 32'h2002, 32'h1234, 0, 1, 0);
    txn(0, 0, 0, 2, 32'h1001, 0, 32'h11223344, 0, 0);
    txn(1, 0, 0, 2, 32'h1001, 0, 32'h11223344, 1, 0);
    txn(1, 0, 1, 1, 32'h3000, 0, 32'h0000_8001, 3, 1);
    txn(1, 1, 0, 0, 32'h4001, 32'hAB, 0, 0, 0);

    // Reset during SHIFT.
    @(negedge clk);
    dsel = 0; we = 0; sgn = 0; word = 1; half = 0;
    adr = 32'h5000; rdt = 32'hFFFF_FFFF; req0 = 1;
    @(negedge clk);
    req0 = 0; ack0 = 1;
    @(negedge clk);
    ack0 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rs_busy", busy0, 0);
    chk("rs_rdv", rdv0, 0);
    chk("rs_done", done0, 0);
    chk("rs_wb", {cyc0, sel0, wbwe0}, 0);
    chk("rs_adr", wadr0, 0);
    rst = 0;

    // Reset during BUS.
    @(negedge clk);
    adr = 32'h6000; req0 = 1;
    @(negedge clk);
    req0 = 0;
    chk("rb_cyc_pre", cyc0, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rb_cyc", cyc0, 0);
    chk("rb_busy", busy0, 0);
    chk("rb_done", {done0, mis0}, 0);
    // Stray ack while idle must be ignored.
    ack0 = 1; ack1 = 1;
    @(negedge clk);
    ack0 = 0; ack1 = 0;
    chk("stray_ack", {busy0, cyc0, done0, rdv0, busy1, cyc1, done1, rdv1}, 0);
    txn(0, 0, 0, 2, 32'h7000, 0, 32'hCAFE_F00D, 0, 0);

    for (int r = 0; r < 40; r++) begin
      int d, sz, dl;
      bit w_e, sg, pk;
      logic [31:0] a, wd, rd_data;
      d = int'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      w_e = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      pk = 1'($urandom_range(0, 1));
      dl = int'($urandom_range(0, 3));
      a = $urandom;
      wd = $urandom;
      rd_data = $urandom;
      txn(d, w_e, sg, sz, a, wd, rd_data, dl, pk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
